// File: rtl/bfly_r2_pipe.sv
// Radix-2 DIT butterfly X = A + W'*B, Y = A - W'*B, optional conj(W); BFLY_SCALE_EN adds a 1/2 output scale.
// Latency 3 cycles; one global enable, so any output stall holds every stage and drops in_ready.
module bfly_r2_pipe #(
    parameter int DW   = 16,
    parameter int TW   = 16,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   in_a,
    input  logic [2*DW-1:0]   in_b,
    input  logic [2*TW-1:0]   in_w,
    input  logic              in_inv,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_x,
    output logic [2*DW-1:0]   out_y,
    output logic [TAGW-1:0]   out_tag,
    output logic              out_sat
);
    localparam int PW  = DW + TW;
    localparam int SW  = PW + 2;
    localparam int QW  = DW + 1;
    localparam int ZW  = DW + 2;
    localparam int SH  = TW - 2;
    localparam int RND = 1 << (TW - 3);
    localparam logic signed [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};

    // Returns {clipped, value} for a signed saturation of SW bits down to QW bits.
    function automatic logic [QW:0] sat_q(input logic signed [SW-1:0] v);
        logic [SW-QW:0] top;
        top = v[SW-1:QW-1];
        if (&top || ~|top) sat_q = {1'b0, v[QW-1:0]};
        else               sat_q = {1'b1, v[SW-1], {(QW-1){~v[SW-1]}}};
    endfunction

    function automatic logic [DW:0] sat_d(input logic signed [ZW-1:0] v);
        logic [ZW-DW:0] top;
        top = v[ZW-1:DW-1];
        if (&top || ~|top) sat_d = {1'b0, v[DW-1:0]};
        else               sat_d = {1'b1, v[ZW-1], {(DW-1){~v[ZW-1]}}};
    endfunction

    function automatic logic signed [ZW-1:0] scale(input logic signed [ZW-1:0] v);
`ifdef BFLY_SCALE_EN
        scale = (v + ZW'(1)) >>> 1;
`else
        scale = v;
`endif
    endfunction

    logic en;
    logic v1, v2, v3;

    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;

    // Stage 1: conjugate twiddle and four full-precision products
    logic signed [DW-1:0] b_re, b_im;
    logic signed [TW-1:0] w_re, w_im, w_im_c;

    assign b_re   = in_b[2*DW-1:DW];
    assign b_im   = in_b[DW-1:0];
    assign w_re   = in_w[2*TW-1:TW];
    assign w_im   = in_w[TW-1:0];
    assign w_im_c = !in_inv ? w_im : (w_im == W_MIN) ? W_MAX : -w_im;

    logic signed [PW-1:0] s1_rr, s1_ii, s1_ri, s1_ir;
    logic [2*DW-1:0]      s1_a;
    logic [TAGW-1:0]      s1_tag;

    // Stage 2: combine, round half-up back to sample scale, clip to DW+1
    logic signed [SW-1:0] pr_w, pi_w;
    logic [QW:0]          pr_q, pi_q;

    assign pr_w = (SW'(s1_rr) - SW'(s1_ii) + SW'(RND)) >>> SH;
    assign pi_w = (SW'(s1_ri) + SW'(s1_ir) + SW'(RND)) >>> SH;
    assign pr_q = sat_q(pr_w);
    assign pi_q = sat_q(pi_w);

    logic signed [QW-1:0] s2_pr, s2_pi;
    logic [2*DW-1:0]      s2_a;
    logic [TAGW-1:0]      s2_tag;
    logic                 s2_sat;

    // Stage 3: A +/- P at DW+2 bits, optional halving, clip to DW
    logic signed [DW-1:0] a_re, a_im;
    logic [DW:0]          xr_q, xi_q, yr_q, yi_q;

    assign a_re = s2_a[2*DW-1:DW];
    assign a_im = s2_a[DW-1:0];
    assign xr_q = sat_d(scale(ZW'(a_re) + ZW'(s2_pr)));
    assign xi_q = sat_d(scale(ZW'(a_im) + ZW'(s2_pi)));
    assign yr_q = sat_d(scale(ZW'(a_re) - ZW'(s2_pr)));
    assign yi_q = sat_d(scale(ZW'(a_im) - ZW'(s2_pi)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_rr   <= '0;
            s1_ii   <= '0;
            s1_ri   <= '0;
            s1_ir   <= '0;
            s1_a    <= '0;
            s1_tag  <= '0;
            s2_pr   <= '0;
            s2_pi   <= '0;
            s2_a    <= '0;
            s2_tag  <= '0;
            s2_sat  <= 1'b0;
            out_x   <= '0;
            out_y   <= '0;
            out_tag <= '0;
            out_sat <= 1'b0;
        end else if (en) begin
            v1      <= in_valid;
            s1_rr   <= PW'(b_re) * PW'(w_re);
            s1_ii   <= PW'(b_im) * PW'(w_im_c);
            s1_ri   <= PW'(b_re) * PW'(w_im_c);
            s1_ir   <= PW'(b_im) * PW'(w_re);
            s1_a    <= in_a;
            s1_tag  <= in_tag;

            v2      <= v1;
            s2_pr   <= pr_q[QW-1:0];
            s2_pi   <= pi_q[QW-1:0];
            s2_a    <= s1_a;
            s2_tag  <= s1_tag;
            s2_sat  <= pr_q[QW] | pi_q[QW];

            v3      <= v2;
            out_x   <= {xr_q[DW-1:0], xi_q[DW-1:0]};
            out_y   <= {yr_q[DW-1:0], yi_q[DW-1:0]};
            out_tag <= s2_tag;
            out_sat <= s2_sat | xr_q[DW] | xi_q[DW] | yr_q[DW] | yi_q[DW];
        end
    end
endmodule

// File: doc/bfly_r2_pipe.md
BFLY_R2_PIPE -- requirements
Module: bfly_r2_pipe

Interface
REQ-001 Parameter DW, default 16: signed component width; a complex word is packed {re, im}, 2*DW bits.
REQ-002 Parameter TW, default 16: signed twiddle component width, format Q1.(TW-2), so 1.0 = 2^(TW-2).
REQ-003 Parameter TAGW, default 4: sideband tag width.
REQ-004 Ports, in order:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block accepts the input beat.
- in_a, in, 2*DW: operand A.
- in_b, in, 2*DW: operand B.
- in_w, in, 2*TW: twiddle W.
- in_inv, in, 1: 1 = use conj(W) (inverse transform).
- in_tag, in, TAGW: tag, passed through unchanged.
- out_valid, out, 1: result beat valid.
- out_ready, in, 1: downstream accepts the result beat.
- out_x, out, 2*DW: X = A + W'*B.
- out_y, out, 2*DW: Y = A - W'*B.
- out_tag, out, TAGW: tag of this result.
- out_sat, out, 1: saturation occurred on any component of this beat.

Function
REQ-005 A transfer occurs on a cycle with valid && ready, on the input side and the output side independently.
REQ-006 Three register stages, with valid bits v1, v2, v3. out_valid = v3. Latency is 3 cycles from input transfer to out_valid with no stall.
REQ-007 Global advance: en = !v3 || out_ready. in_ready = en (combinational). When en = 0, all stage registers hold.
REQ-008 Bubbles are not collapsed. Sustained throughput is 1 beat/cycle while out_ready = 1.
REQ-009 While out_valid = 1 && out_ready = 0, out_x, out_y, out_tag and out_sat shall hold stable.
REQ-010 W' = (wr, -wi) when in_inv = 1, else (wr, wi). Negating -2^(TW-1) saturates to 2^(TW-1)-1.
REQ-011 Stage 1 registers four full-precision products: br*wr', bi*wi', br*wi', bi*wr'.
REQ-012 Stage 2 forms pr = br*wr' - bi*wi' and pi = br*wi' + bi*wr'.
- Round half-up: add 2^(TW-3), then arithmetic shift right by TW-2.
- Saturate to DW+1 bits; set the beat's sat flag if clipped.
- Register A alongside.
REQ-013 Stage 3 forms A±P per component at DW+2 bits, then scales (REQ-020) and saturates to DW bits. Any clip sets out_sat.
REQ-014 The tag and sat flag travel with the beat through all stages.
REQ-015 Simultaneous input and output transfer in one cycle is legal, and the pipeline advances normally.

Reset
REQ-016 While rst_n = 0, the following are 0: v1, v2, v3, out_valid, out_x, out_y, out_tag, out_sat.
REQ-017 in_ready = 1 during and after reset (v3 = 0).
REQ-018 Reset asserted mid-operation discards all in-flight beats. No result is emitted for them after reset release.
REQ-019 The first input transfer is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-020 Macro BFLY_SCALE_EN.
- Defined: stage 3 output = (sum + 1) >>> 1 before DW saturation, giving per-stage 1/2 scaling for FFT growth control.
- Undefined: output = sum, saturated to DW.
- Latency, handshake and ports are identical in both builds.

Verification (DW=16, TW=16, 1.0=16384)
REQ-021 A=(1000,0), B=(500,0), W=(16384,0), inv=0, tag=5 -> 3 cycles later X=(1500,0), Y=(500,0), tag=5, sat=0. With BFLY_SCALE_EN: X=(750,0), Y=(250,0).
REQ-022 A=(0,0), B=(100,200), W=(0,-16384): inv=0 -> X=(200,-100), Y=(-200,100); inv=1 -> X=(-200,100), Y=(200,-100).
REQ-023 A=(32767,0), B=(32767,0), W=(16384,0) -> without macro X=(32767,0), sat=1; with macro X=(32767,0), Y=(0,0), sat=0.
REQ-024 Stream 8 beats with tags 0..7, holding out_ready=0 for cycles 4-9 -> in_ready=0 whenever v3=1 && !out_ready, outputs held stable, all 8 results in tag order, no loss or duplication.
REQ-025 Pulse rst_n low with 3 beats in flight -> out_valid=0 immediately. After release, the next accepted beat is the only one emitted.
REQ-026 Back-to-back beats with out_ready=1 -> one result per cycle, each matching a reference model bit-exactly (500 random vectors, both inv values).
